// File: rtl/sobel_cfg_pkg.sv
// Shared types and default widths for the sobel register-side controller.
package sobel_cfg_pkg;

   localparam int unsigned AXI_W           = 32;
   localparam int unsigned COEF_ADDR_W_DEF = 5;
   localparam int unsigned COEF_W_DEF      = 18;
   localparam int unsigned HIST_ADDR_W_DEF = 8;
   localparam int unsigned HIST_LAT_DEF    = 2;
   localparam int unsigned FIFO_DEPTH_DEF  = 4;
   localparam int unsigned LAT_CNT_W       = 3;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_ISSUE,
      RD_WAIT,
      RD_ACK
   } rd_state_e;

   typedef struct packed {
      logic [COEF_ADDR_W_DEF-1:0] addr;
      logic [COEF_W_DEF-1:0]      data;
   } wr_entry_t;

endpackage

// File: rtl/sobel_cfg_ctrl_cfg_wr_fifo.sv
// Small synchronous FIFO buffering coefficient writes until blanking.
module cfg_wr_fifo #(
   parameter int unsigned W     = 23,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] head_c,
   output logic         full_c,
   output logic         empty_c
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW:0]   wr_ptr_q, wr_ptr_d;
   logic [PW:0]   rd_ptr_q, rd_ptr_d;
   logic          push_ok, pop_ok;

   assign empty_c = (wr_ptr_q == rd_ptr_q);
   assign full_c  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign head_c  = mem_q[rd_ptr_q[PW-1:0]];

   // A push into a full FIFO is legal only when the head leaves the same cycle.
   assign push_ok = push_i & (~full_c | pop_i);
   assign pop_ok  = pop_i & ~empty_c;

   always_comb begin
      wr_ptr_d = wr_ptr_q + CW'(push_ok);
      rd_ptr_d = rd_ptr_q + CW'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/sobel_cfg_ctrl.sv
// AXI-strobe register controller: blanking-gated coefficient commit,
// fixed-latency histogram reads and a per-frame bank-swap pulse.
module sobel_cfg_ctrl
   import sobel_cfg_pkg::*;
#(
   parameter int unsigned COEF_ADDR_W = COEF_ADDR_W_DEF,
   parameter int unsigned COEF_W      = COEF_W_DEF,
   parameter int unsigned HIST_ADDR_W = HIST_ADDR_W_DEF,
   parameter int unsigned HIST_LAT    = HIST_LAT_DEF,
   parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   axi_wr_strobe_i,
   input  logic                   axi_rd_strobe_i,
   input  logic [AXI_W-1:0]       fir_addr_i,
   input  logic [AXI_W-1:0]       fir_coeff_i,
   output logic                   axi_wr_ack_o,
   output logic                   axi_rd_ack_o,
   output logic [AXI_W-1:0]       hist_bin_o,
   input  logic                   vs_i,
   output logic                   coef_we_o,
   output logic [COEF_ADDR_W-1:0] coef_addr_o,
   output logic [COEF_W-1:0]      coef_data_o,
   output logic                   hist_rd_en_o,
   output logic [HIST_ADDR_W-1:0] hist_rd_addr_o,
   input  logic [AXI_W-1:0]       hist_rd_data_i,
   output logic                   hist_swap_o,
   output logic                   cfg_err_o
);

   localparam int unsigned EW = COEF_ADDR_W + COEF_W;

   logic                   wr_prev_q, rd_prev_q, vs_prev_q;
   logic                   wr_ack_q, wr_ack_d;
   logic                   err_q, err_d;
   logic                   pend_q, pend_d;
   logic [EW-1:0]          pend_entry_q, pend_entry_d;
   logic                   coef_we_q, coef_we_d;
   logic [COEF_ADDR_W-1:0] coef_addr_q, coef_addr_d;
   logic [COEF_W-1:0]      coef_data_q, coef_data_d;
   logic                   swap_q, swap_d;
   rd_state_e              rd_state_q, rd_state_d;
   logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
   logic                   rd_en_q, rd_en_d;
   logic [HIST_ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic                   rd_ack_q, rd_ack_d;
   logic [AXI_W-1:0]       hist_bin_q, hist_bin_d;

   logic                   wr_req_c, rd_req_c, addr_oor_c;
   logic                   push_c, pop_c, can_push_c;
   logic [EW-1:0]          new_entry_c, push_data_c, head_c;
   logic                   full_c, empty_c;
   logic                   unused_coeff_hi;

   assign unused_coeff_hi = ^fir_coeff_i[AXI_W-1:COEF_W];

   assign wr_req_c    = axi_wr_strobe_i & ~wr_prev_q;
   assign rd_req_c    = axi_rd_strobe_i & ~rd_prev_q;
   assign addr_oor_c  = |fir_addr_i[AXI_W-1:COEF_ADDR_W];
   assign new_entry_c = {fir_addr_i[COEF_ADDR_W-1:0], fir_coeff_i[COEF_W-1:0]};
   assign pop_c       = vs_i & ~empty_c;
   assign can_push_c  = ~full_c | pop_c;

   cfg_wr_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_c),
      .pop_i   (pop_c),
      .wdata_i (push_data_c),
      .head_c  (head_c),
      .full_c  (full_c),
      .empty_c (empty_c)
   );

   // Write acceptance, pending-on-full, error tracking and blanking drain.
   always_comb begin
      wr_ack_d     = 1'b0;
      err_d        = err_q;
      pend_d       = pend_q;
      pend_entry_d = pend_entry_q;
      push_c       = 1'b0;
      push_data_c  = new_entry_c;

      if (pend_q) begin
         if (can_push_c) begin
            push_c      = 1'b1;
            push_data_c = pend_entry_q;
            wr_ack_d    = 1'b1;
            pend_d      = 1'b0;
         end
         if (wr_req_c) err_d = 1'b1;
      end else if (wr_req_c) begin
         if (addr_oor_c) begin
            wr_ack_d = 1'b1;
            err_d    = 1'b1;
         end else if (can_push_c) begin
            push_c   = 1'b1;
            wr_ack_d = 1'b1;
         end else begin
            pend_d       = 1'b1;
            pend_entry_d = new_entry_c;
         end
      end

      coef_we_d   = pop_c;
      coef_addr_d = pop_c ? head_c[EW-1:COEF_W] : coef_addr_q;
      coef_data_d = pop_c ? head_c[COEF_W-1:0]  : coef_data_q;
      swap_d      = vs_i & ~vs_prev_q;
   end

   // Histogram read FSM; outputs are registered so they line up with the state.
   always_comb begin
      rd_state_d = rd_state_q;
      lat_cnt_d  = lat_cnt_q;
      rd_en_d    = 1'b0;
      rd_addr_d  = rd_addr_q;
      rd_ack_d   = 1'b0;
      hist_bin_d = hist_bin_q;

      case (rd_state_q)
         RD_IDLE: begin
            if (rd_req_c) begin
               rd_state_d = RD_ISSUE;
               rd_en_d    = 1'b1;
               rd_addr_d  = fir_addr_i[HIST_ADDR_W-1:0];
            end
         end
         RD_ISSUE: begin
            rd_state_d = RD_WAIT;
            lat_cnt_d  = '0;
         end
         RD_WAIT: begin
            if (lat_cnt_q == LAT_CNT_W'(HIST_LAT - 1)) begin
               rd_state_d = RD_ACK;
               rd_ack_d   = 1'b1;
               hist_bin_d = hist_rd_data_i;
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_CNT_W'(1);
            end
         end
         RD_ACK:  rd_state_d = RD_IDLE;
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_prev_q    <= 1'b0;
         rd_prev_q    <= 1'b0;
         vs_prev_q    <= 1'b0;
         wr_ack_q     <= 1'b0;
         err_q        <= 1'b0;
         pend_q       <= 1'b0;
         pend_entry_q <= '0;
         coef_we_q    <= 1'b0;
         coef_addr_q  <= '0;
         coef_data_q  <= '0;
         swap_q       <= 1'b0;
         rd_state_q   <= RD_IDLE;
         lat_cnt_q    <= '0;
         rd_en_q      <= 1'b0;
         rd_addr_q    <= '0;
         rd_ack_q     <= 1'b0;
         hist_bin_q   <= '0;
      end else begin
         wr_prev_q    <= axi_wr_strobe_i;
         rd_prev_q    <= axi_rd_strobe_i;
         vs_prev_q    <= vs_i;
         wr_ack_q     <= wr_ack_d;
         err_q        <= err_d;
         pend_q       <= pend_d;
         pend_entry_q <= pend_entry_d;
         coef_we_q    <= coef_we_d;
         coef_addr_q  <= coef_addr_d;
         coef_data_q  <= coef_data_d;
         swap_q       <= swap_d;
         rd_state_q   <= rd_state_d;
         lat_cnt_q    <= lat_cnt_d;
         rd_en_q      <= rd_en_d;
         rd_addr_q    <= rd_addr_d;
         rd_ack_q     <= rd_ack_d;
         hist_bin_q   <= hist_bin_d;
      end
   end

   assign axi_wr_ack_o   = wr_ack_q;
   assign axi_rd_ack_o   = rd_ack_q;
   assign hist_bin_o     = hist_bin_q;
   assign coef_we_o      = coef_we_q;
   assign coef_addr_o    = coef_addr_q;
   assign coef_data_o    = coef_data_q;
   assign hist_rd_en_o   = rd_en_q;
   assign hist_rd_addr_o = rd_addr_q;
   assign hist_swap_o    = swap_q;
   assign cfg_err_o      = err_q;

endmodule

// File: tb/tb_sobel_cfg_ctrl.sv
// Bench for sobel_cfg_ctrl: queue-based model checked every cycle, plus directed literal checks.
module tb_sobel_cfg_ctrl;

   localparam int L     = 2;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  a;
      logic [17:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        axi_wr_strobe_i = 1'b0;
   logic        axi_rd_strobe_i = 1'b0;
   logic [31:0] fir_addr_i = '0;
   logic [31:0] fir_coeff_i = '0;
   logic        vs_i = 1'b0;
   logic [31:0] hist_rd_data_i = '0;
   logic        axi_wr_ack_o, axi_rd_ack_o, coef_we_o, hist_rd_en_o, hist_swap_o, cfg_err_o;
   logic [31:0] hist_bin_o;
   logic [4:0]  coef_addr_o;
   logic [17:0] coef_data_o;
   logic [7:0]  hist_rd_addr_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sobel_cfg_ctrl #(
      .COEF_ADDR_W (5), .COEF_W (18), .HIST_ADDR_W (8), .HIST_LAT (L), .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .axi_wr_strobe_i (axi_wr_strobe_i), .axi_rd_strobe_i (axi_rd_strobe_i),
      .fir_addr_i (fir_addr_i), .fir_coeff_i (fir_coeff_i),
      .axi_wr_ack_o (axi_wr_ack_o), .axi_rd_ack_o (axi_rd_ack_o), .hist_bin_o (hist_bin_o),
      .vs_i (vs_i), .coef_we_o (coef_we_o), .coef_addr_o (coef_addr_o), .coef_data_o (coef_data_o),
      .hist_rd_en_o (hist_rd_en_o), .hist_rd_addr_o (hist_rd_addr_o),
      .hist_rd_data_i (hist_rd_data_i), .hist_swap_o (hist_swap_o), .cfg_err_o (cfg_err_o)
   );

   // Histogram RAM: data valid L cycles after the enable, junk otherwise.
   function automatic logic [31:0] ram_word(input logic [7:0] a);
      return (a == 8'h17) ? 32'hDEADBEEF : {24'h5A5A5A, a};
   endfunction

   logic        d1_en = 1'b0;
   logic [7:0]  d1_addr = '0;
   logic [31:0] cyc = '0;
   always @(posedge clk) begin
      cyc            <= cyc + 32'd1;
      d1_en          <= hist_rd_en_o;
      d1_addr        <= hist_rd_addr_o;
      hist_rd_data_i <= d1_en ? ram_word(d1_addr) : (32'hBAD00000 | cyc);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: outputs expected during the next cycle.
   ent_t        q[$];
   bit          pend;
   ent_t        pend_e;
   bit          m_err, wr_p, rd_p, vs_p;
   int          rd_t;
   bit          exp_wr_ack, exp_rd_ack, exp_rd_en, exp_we, exp_swap;
   logic [31:0] exp_bin;
   logic [7:0]  exp_rd_addr;
   logic [4:0]  exp_caddr;
   logic [17:0] exp_cdata;

   task automatic model_reset();
      q.delete();
      pend = 0; m_err = 0; wr_p = 0; rd_p = 0; vs_p = 0; rd_t = 0;
      exp_wr_ack = 0; exp_rd_ack = 0; exp_rd_en = 0; exp_we = 0; exp_swap = 0;
      exp_bin = '0; exp_rd_addr = '0; exp_caddr = '0; exp_cdata = '0;
   endtask

   task automatic model_step();
      bit   wr_req, rd_req;
      ent_t e;
      wr_req = axi_wr_strobe_i && !wr_p;
      rd_req = axi_rd_strobe_i && !rd_p;
      e.a = fir_addr_i[4:0];
      e.d = fir_coeff_i[17:0];
      exp_wr_ack = 0; exp_we = 0; exp_rd_en = 0; exp_rd_ack = 0;
      if (vs_i && q.size() > 0) begin
         exp_we    = 1;
         exp_caddr = q[0].a;
         exp_cdata = q[0].d;
         void'(q.pop_front());
      end
      if (pend) begin
         if (q.size() < DEPTH) begin
            q.push_back(pend_e); pend = 0; exp_wr_ack = 1;
         end
         if (wr_req) m_err = 1;
      end else if (wr_req) begin
         if (fir_addr_i >= 32) begin
            exp_wr_ack = 1; m_err = 1;
         end else if (q.size() < DEPTH) begin
            q.push_back(e); exp_wr_ack = 1;
         end else begin
            pend = 1; pend_e = e;
         end
      end
      exp_swap = vs_i && !vs_p;
      // Read: issue one cycle after the edge, ack L+2 cycles after it.
      if (rd_t == 0) begin
         if (rd_req) begin
            rd_t = 1; exp_rd_en = 1; exp_rd_addr = fir_addr_i[7:0];
         end
      end else if (rd_t == L + 2) begin
         rd_t = 0;
      end else begin
         if (rd_t == L + 1) begin
            exp_rd_ack = 1; exp_bin = hist_rd_data_i;
         end
         rd_t++;
      end
      wr_p = axi_wr_strobe_i; rd_p = axi_rd_strobe_i; vs_p = vs_i;
   endtask

   ent_t log_q[$];
   int   n_wr_ack = 0, n_rd_ack = 0, n_swap = 0;

   always @(negedge clk) begin
      if (!rst_n) model_reset();
      chk("wr_ack",   32'(axi_wr_ack_o), 32'(exp_wr_ack));
      chk("rd_ack",   32'(axi_rd_ack_o), 32'(exp_rd_ack));
      chk("hist_bin", hist_bin_o, exp_bin);
      chk("rd_en",    32'(hist_rd_en_o), 32'(exp_rd_en));
      if (exp_rd_en) chk("rd_addr", 32'(hist_rd_addr_o), 32'(exp_rd_addr));
      chk("coef_we",  32'(coef_we_o), 32'(exp_we));
      if (exp_we) begin
         chk("coef_addr", 32'(coef_addr_o), 32'(exp_caddr));
         chk("coef_data", 32'(coef_data_o), 32'(exp_cdata));
      end
      chk("swap", 32'(hist_swap_o), 32'(exp_swap));
      chk("err",  32'(cfg_err_o), 32'(m_err));
      if (axi_wr_ack_o) n_wr_ack++;
      if (axi_rd_ack_o) n_rd_ack++;
      if (hist_swap_o)  n_swap++;
      if (coef_we_o)    log_q.push_back({coef_addr_o, coef_data_o});
      if (rst_n) model_step();
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] log_at(input int i);
      return (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFFFFFF;
   endfunction

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit ack_now, input string nm);
      fir_addr_i = a; fir_coeff_i = d; axi_wr_strobe_i = 1'b1;
      tick(1);
      chk(nm, 32'(axi_wr_ack_o), 32'(ack_now));
      axi_wr_strobe_i = 1'b0;
      tick(1);
   endtask

   task automatic vs_pulse(input int hi, input int lo);
      vs_i = 1'b1; tick(hi); vs_i = 1'b0; tick(lo);
   endtask

   int base_ack, base_swap, base_rd;

   initial begin
      tick(3);
      chk("rst_err", 32'(cfg_err_o), 32'd0);
      chk("rst_we",  32'(coef_we_o), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Single write buffered until blanking.
      log_q.delete(); base_swap = n_swap;
      do_write(32'd3, 32'h0001ABCD, 1, "t1_ack_edge1");
      tick(4);
      chk("t1_no_commit", 32'(log_q.size()), 32'd0);
      vs_pulse(4, 2);
      chk("t1_commits", 32'(log_q.size()), 32'd1);
      chk("t1_entry", log_at(0), 32'({5'd3, 18'h1ABCD}));
      chk("t1_swap", 32'(n_swap - base_swap), 32'd1);

      // Overfill: fifth write waits for a free slot.
      log_q.delete(); base_ack = n_wr_ack;
      for (int i = 0; i < 5; i++) do_write(32'(i), 32'h100 + 32'(i), i < 4, "t2_ack");
      tick(2);
      chk("t2_acks_full", 32'(n_wr_ack - base_ack), 32'd4);
      vs_pulse(8, 2);
      chk("t2_acks_all", 32'(n_wr_ack - base_ack), 32'd5);
      chk("t2_commits", 32'(log_q.size()), 32'd5);
      for (int i = 0; i < 5; i++) chk("t2_order", log_at(i), 32'({5'(i), 18'h100 + 18'(i)}));

      // Out-of-range address: acked, not queued, sticky error.
      log_q.delete();
      do_write(32'd40, 32'h2222, 1, "t3_ack");
      chk("t3_err", 32'(cfg_err_o), 32'd1);
      vs_pulse(3, 2);
      chk("t3_no_push", 32'(log_q.size()), 32'd0);
      chk("t3_err_sticky", 32'(cfg_err_o), 32'd1);

      // Histogram read, with a second edge while busy that must be ignored.
      base_rd = n_rd_ack;
      fir_addr_i = 32'h17; axi_rd_strobe_i = 1'b1;
      tick(1);
      chk("t4_rd_en", 32'(hist_rd_en_o), 32'd1);
      chk("t4_rd_addr", 32'(hist_rd_addr_o), 32'h17);
      axi_rd_strobe_i = 1'b0; tick(1);
      axi_rd_strobe_i = 1'b1; tick(1);
      axi_rd_strobe_i = 1'b0; tick(1);
      chk("t4_rd_ack", 32'(axi_rd_ack_o), 32'd1);
      chk("t4_bin", hist_bin_o, 32'hDEADBEEF);
      tick(6);
      chk("t4_bin_held", hist_bin_o, 32'hDEADBEEF);
      chk("t4_one_ack", 32'(n_rd_ack - base_rd), 32'd1);

      // Simultaneous read and write edges.
      log_q.delete();
      fir_addr_i = 32'h9; fir_coeff_i = 32'h30009;
      axi_wr_strobe_i = 1'b1; axi_rd_strobe_i = 1'b1;
      tick(1);
      chk("t4b_wr_ack", 32'(axi_wr_ack_o), 32'd1);
      chk("t4b_rd_en", 32'(hist_rd_en_o), 32'd1);
      axi_wr_strobe_i = 1'b0; axi_rd_strobe_i = 1'b0;
      tick(3);
      chk("t4b_rd_ack", 32'(axi_rd_ack_o), 32'd1);
      chk("t4b_bin", hist_bin_o, 32'h5A5A5A09);
      vs_pulse(3, 2);
      chk("t4b_entry", log_at(0), 32'({5'd9, 18'h30009}));

      // Short blanking: two commits, the third waits for the next frame.
      log_q.delete(); base_swap = n_swap;
      for (int i = 5; i < 8; i++) do_write(32'(i), 32'h200 + 32'(i), 1, "t5_ack");
      vs_pulse(2, 3);
      chk("t5_two", 32'(log_q.size()), 32'd2);
      chk("t5_swap1", 32'(n_swap - base_swap), 32'd1);
      tick(3);
      vs_pulse(3, 2);
      chk("t5_three", 32'(log_q.size()), 32'd3);
      chk("t5_third", log_at(2), 32'({5'd7, 18'h207}));
      chk("t5_swap2", 32'(n_swap - base_swap), 32'd2);

      // Reset with writes queued and a read in flight.
      do_write(32'd10, 32'h10A, 1, "t6_ack");
      do_write(32'd11, 32'h10B, 1, "t6_ack");
      fir_addr_i = 32'h20; axi_rd_strobe_i = 1'b1;
      tick(1);
      axi_rd_strobe_i = 1'b0;
      tick(1);
      rst_n = 1'b0;
      #1;
      chk("t6_wr_ack", 32'(axi_wr_ack_o), 32'd0);
      chk("t6_rd_ack", 32'(axi_rd_ack_o), 32'd0);
      chk("t6_bin", hist_bin_o, 32'd0);
      chk("t6_rd_en", 32'(hist_rd_en_o), 32'd0);
      chk("t6_err", 32'(cfg_err_o), 32'd0);
      chk("t6_we", 32'(coef_we_o), 32'd0);
      tick(2);
      rst_n = 1'b1;
      log_q.delete(); base_rd = n_rd_ack; base_ack = n_wr_ack;
      tick(6);
      vs_pulse(4, 3);
      chk("t6_no_commit", 32'(log_q.size()), 32'd0);
      chk("t6_no_rd_ack", 32'(n_rd_ack - base_rd), 32'd0);
      chk("t6_no_wr_ack", 32'(n_wr_ack - base_ack), 32'd0);
      chk("t6_err_after", 32'(cfg_err_o), 32'd0);

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
